// File: rtl/axil_regfile_slave_pkg.sv
// Shared response codes, channel FSM encodings and address decode helper
// for the AXI4-Lite register file slave.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_NEED_W,
    W_NEED_AW,
    W_COMMIT,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Word index of a byte address; the byte-offset bits inside a word are dropped.
  // Kept 64 bits wide so the caller can range-check against NUM_REGS without
  // losing any high address bits.
  function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                input int unsigned off_bits);
    return addr >> off_bits;
  endfunction

endpackage

// File: rtl/axil_regfile_slave_if.sv
// AXI4-Lite bus bundle (five channels) with slave and master views.
interface axil_regfile_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_W-1:0]     AWADDR;
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_W-1:0]     ARADDR;
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_W-1:0]     RDATA;
  logic [1:0]            RRESP;

  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/axil_regfile_slave_reg_bank.sv
// Register array: byte-strobed writes, read-only slots fed live from ro_i,
// combinational read port and one-cycle write pulses.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int                   DATA_W    = 32,
  parameter int                   NUM_REGS  = 16,
  parameter int                   IDX_W     = 4,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_en_i,
  input  logic [IDX_W-1:0]             wr_idx_i,
  input  logic [DATA_W-1:0]            wr_data_i,
  input  logic [DATA_W/8-1:0]          wr_strb_i,
  input  logic [IDX_W-1:0]             rd_idx_i,
  output logic [DATA_W-1:0]            rd_data_o,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_i,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int STRB_W = DATA_W / 8;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             pulse_q, pulse_d;
  logic                            unused_ro;

  // Slots of ro_i belonging to writable registers are deliberately ignored.
  assign unused_ro = ^ro_i;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign regs[i] = ro_i[i*DATA_W +: DATA_W];
    end else begin : g_rw
      logic [DATA_W-1:0] val_q, val_d;

      // Merge strobed byte lanes when this slot is the commit target.
      always_comb begin
        val_d = val_q;
        if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb_i[b]) val_d[b*8 +: 8] = wr_data_i[b*8 +: 8];
          end
        end
      end

      // Register storage.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) val_q <= RESET_VAL;
        else       val_q <= val_d;
      end

      assign regs[i] = val_q;
    end
    assign reg_q_o[i*DATA_W +: DATA_W] = regs[i];
  end

  // Pulse fires for any commit to a writable slot, even with all strobes low.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pulse_d[i] = wr_en_i && (wr_idx_i == IDX_W'(i)) && !RO_MASK[i];
    end
  end

  // Delay the pulse so it lines up with the updated register value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pulse_q <= '0;
    else       pulse_q <= pulse_d;
  end

  assign wr_pulse_o = pulse_q;

  // Read mux written as a loop so non-power-of-two bank sizes never index past the end.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx_i == IDX_W'(i)) rd_data_o = regs[i];
    end
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite register file slave: independent write and read channel FSMs
// in front of axil_reg_bank.
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int                   DATA_W    = 32,
  parameter int                   ADDR_W    = 32,
  parameter int                   NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  axil_regfile_slave_if.slave         s_axil,
  input  logic [NUM_REGS*DATA_W-1:0]  RO_IN,
  output logic [NUM_REGS*DATA_W-1:0]  REG_Q,
  output logic [NUM_REGS-1:0]         WR_PULSE
);

  localparam int          STRB_W   = DATA_W / 8;
  localparam int unsigned OFF_BITS = $clog2(STRB_W);
  localparam int          IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  wr_state_e           wst_q, wst_d;
  rd_state_e           rst_q, rst_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                awready, wready, wr_en;
  logic [63:0]         widx64, ridx64;
  logic                w_in_range, r_in_range;
  logic [DATA_W-1:0]   bank_rd;

  assign widx64     = addr_to_index(64'(awaddr_q), OFF_BITS);
  assign ridx64     = addr_to_index(64'(s_axil.ARADDR), OFF_BITS);
  assign w_in_range = widx64 < 64'(NUM_REGS);
  assign r_in_range = ridx64 < 64'(NUM_REGS);

  axil_reg_bank #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .RO_MASK   (RO_MASK),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .wr_en_i    (wr_en),
    .wr_idx_i   (widx64[IDX_W-1:0]),
    .wr_data_i  (wdata_q),
    .wr_strb_i  (wstrb_q),
    .rd_idx_i   (ridx64[IDX_W-1:0]),
    .rd_data_o  (bank_rd),
    .ro_i       (RO_IN),
    .reg_q_o    (REG_Q),
    .wr_pulse_o (WR_PULSE)
  );

  // Write channel state and captured AW/W payload.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wst_q    <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wst_q    <= wst_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
    end
  end

  // Write FSM: collect AW and W in any order, commit for one cycle, then hold B.
  always_comb begin
    wst_d    = wst_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    awready  = 1'b0;
    wready   = 1'b0;
    wr_en    = 1'b0;
    unique case (wst_q)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (s_axil.AWVALID) awaddr_d = s_axil.AWADDR;
        if (s_axil.WVALID) begin
          wdata_d = s_axil.WDATA;
          wstrb_d = s_axil.WSTRB;
        end
        if (s_axil.AWVALID && s_axil.WVALID) wst_d = W_COMMIT;
        else if (s_axil.AWVALID)             wst_d = W_NEED_W;
        else if (s_axil.WVALID)              wst_d = W_NEED_AW;
      end
      W_NEED_W: begin
        wready = 1'b1;
        if (s_axil.WVALID) begin
          wdata_d = s_axil.WDATA;
          wstrb_d = s_axil.WSTRB;
          wst_d   = W_COMMIT;
        end
      end
      W_NEED_AW: begin
        awready = 1'b1;
        if (s_axil.AWVALID) begin
          awaddr_d = s_axil.AWADDR;
          wst_d    = W_COMMIT;
        end
      end
      W_COMMIT: begin
        // RO targets are filtered inside the bank and still answer OKAY.
        wr_en   = w_in_range;
        bresp_d = w_in_range ? RESP_OKAY : RESP_SLVERR;
        wst_d   = W_RESP;
      end
      W_RESP: begin
        if (s_axil.BREADY) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  assign s_axil.AWREADY = awready;
  assign s_axil.WREADY  = wready;
  assign s_axil.BVALID  = (wst_q == W_RESP);
  assign s_axil.BRESP   = bresp_q;

  // Read channel state and registered response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rst_q   <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      rst_q   <= rst_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  // Read FSM: sample the bank on the AR handshake edge, hold until RREADY.
  // Sampling the pre-edge bank value gives old data on a same-edge write.
  always_comb begin
    rst_d   = rst_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    unique case (rst_q)
      R_IDLE: begin
        if (s_axil.ARVALID) begin
          rdata_d = r_in_range ? bank_rd : '0;
          rresp_d = r_in_range ? RESP_OKAY : RESP_SLVERR;
          rst_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axil.RREADY) rst_d = R_IDLE;
      end
      default: rst_d = R_IDLE;
    endcase
  end

  assign s_axil.ARREADY = (rst_q == R_IDLE);
  assign s_axil.RVALID  = (rst_q == R_DATA);
  assign s_axil.RDATA   = rdata_q;
  assign s_axil.RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed plus randomized bench for axil_regfile_slave against a word-array model.
module tb_axil_regfile_slave;

  localparam int                DW = 32;
  localparam int                AW = 32;
  localparam int                NR = 16;
  localparam logic [NR-1:0]     RO = 16'h0008;
  localparam logic [DW-1:0]     RV = '0;

  logic                ACLK;
  logic                ARESET;
  logic [NR*DW-1:0]    RO_IN;
  logic [NR*DW-1:0]    REG_Q;
  logic [NR-1:0]       WR_PULSE;

  axil_regfile_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  axil_regfile_slave #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RV)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .s_axil   (bus),
    .RO_IN    (RO_IN),
    .REG_Q    (REG_Q),
    .WR_PULSE (WR_PULSE)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] mdl [NR];
  logic [1:0]  bresp_exp;

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] exp_regq();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = RO[i] ? RO_IN[i*DW +: DW] : mdl[i];
    return v;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < NR; i++) mdl[i] = RV;
  endtask

  // Word-level view: index = addr/4, out of range -> SLVERR, RO -> OKAY and no change.
  task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [NR-1:0] pulse);
    logic [31:0] idx;
    idx   = addr / 4;
    resp  = 2'b00;
    pulse = '0;
    if (idx >= NR) resp = 2'b10;
    else if (!RO[idx]) begin
      pulse[idx] = 1'b1;
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic mdl_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] idx;
    idx = addr / 4;
    if (idx >= NR)   begin data = '0; resp = 2'b10; end
    else if (RO[idx]) begin data = RO_IN[idx*DW +: DW]; resp = 2'b00; end
    else             begin data = mdl[idx]; resp = 2'b00; end
  endtask

  // Present AW after awd cycles and W after wd cycles, then check the commit cycle.
  task automatic wr_issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awd, input int wd);
    bit aw_p, w_p, aw_f, w_f;
    int cyc;
    logic [NR-1:0] pexp;
    aw_p = 1; w_p = 1; cyc = 0;
    while ((aw_p || w_p) && cyc < 50) begin
      bus.AWADDR  = addr;
      bus.WDATA   = data;
      bus.WSTRB   = strb;
      bus.AWVALID = aw_p && (cyc >= awd);
      bus.WVALID  = w_p && (cyc >= wd);
      aw_f = bus.AWVALID && bus.AWREADY;
      w_f  = bus.WVALID && bus.WREADY;
      @(posedge ACLK); #1;
      if (aw_f) aw_p = 0;
      if (w_f)  w_p  = 0;
      cyc++;
      bus.AWVALID = 0;
      bus.WVALID  = 0;
      if (!aw_p && w_p) chk("awready_low_wait_w", bus.AWREADY, 0);
      if (aw_p && !w_p) chk("wready_low_wait_aw", bus.WREADY, 0);
    end
    chk("wr_handshakes_done", {aw_p, w_p}, 0);
    chk("bvalid_low_in_commit", bus.BVALID, 0);
    mdl_write(addr, data, strb, bresp_exp, pexp);
    @(posedge ACLK); #1;
    chk("bvalid_set", bus.BVALID, 1);
    chk("bresp", bus.BRESP, bresp_exp);
    chk("wr_pulse", WR_PULSE, pexp);
    chk("reg_q_after_write", REG_Q, exp_regq());
  endtask

  // Hold BREADY low for bdly cycles checking B stays put, then accept.
  task automatic wr_resp(input int bdly);
    for (int k = 0; k < bdly; k++) begin
      @(posedge ACLK); #1;
      chk("bvalid_held", bus.BVALID, 1);
      chk("bresp_held", bus.BRESP, bresp_exp);
    end
    bus.BREADY = 1;
    @(posedge ACLK); #1;
    bus.BREADY = 0;
    chk("bvalid_cleared", bus.BVALID, 0);
    chk("wr_pulse_one_cycle", WR_PULSE, 0);
    chk("wr_readys_back", {bus.AWREADY, bus.WREADY}, 2'b11);
  endtask

  task automatic rd(input logic [31:0] addr, input int rdly);
    int cyc;
    logic [31:0] d;
    logic [1:0]  r;
    bus.ARADDR  = addr;
    bus.ARVALID = 1;
    cyc = 0;
    while (!bus.ARREADY && cyc < 20) begin @(posedge ACLK); #1; cyc++; end
    chk("arready_seen", bus.ARREADY, 1);
    mdl_read(addr, d, r);
    @(posedge ACLK); #1;
    bus.ARVALID = 0;
    chk("rvalid_set", bus.RVALID, 1);
    chk("arready_low", bus.ARREADY, 0);
    chk("rdata", bus.RDATA, d);
    chk("rresp", bus.RRESP, r);
    for (int k = 0; k < rdly; k++) begin
      @(posedge ACLK); #1;
      chk("rdata_held", {bus.RVALID, bus.RRESP, bus.RDATA}, {1'b1, r, d});
    end
    bus.RREADY = 1;
    @(posedge ACLK); #1;
    bus.RREADY = 0;
    chk("rvalid_cleared", bus.RVALID, 0);
    chk("arready_back", bus.ARREADY, 1);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    ARESET = 1;
    bus.AWVALID = 0; bus.AWADDR = '0; bus.WVALID = 0; bus.WDATA = '0; bus.WSTRB = '0;
    bus.BREADY = 0;  bus.ARVALID = 0; bus.ARADDR = '0; bus.RREADY = 0;
    for (int i = 0; i < NR; i++) RO_IN[i*DW +: DW] = $urandom;
    RO_IN[3*DW +: DW] = 32'hCAFEF00D;
    mdl_reset();
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    chk("reset_valids", {bus.BVALID, bus.RVALID}, 2'b00);
    chk("reset_resp_data", {bus.BRESP, bus.RRESP, bus.RDATA}, 0);
    chk("reset_regq", REG_Q, exp_regq());
    chk("reset_pulse", WR_PULSE, 0);
    ARESET = 0;
    @(posedge ACLK); #1;

    // 1: AW and W together
    wr_issue(32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    wr_resp(0);
    // 2: W first, AW three cycles later, partial strobe
    wr_issue(32'h08, 32'h12345678, 4'h3, 3, 0);
    wr_resp(1);
    // 3: out of range read and write
    rd(32'h40, 0);
    wr_issue(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0);
    wr_resp(0);
    // 4: read-only register
    wr_issue(32'h0C, 32'h1, 4'hF, 1, 0);
    wr_resp(0);
    rd(32'h0C, 1);
    // 5: stalled B channel does not block a read
    wr_issue(32'h14, 32'hA5A5A5A5, 4'hF, 0, 2);
    rd(32'h04, 2);
    chk("bvalid_during_read", {bus.BVALID, bus.BRESP}, {1'b1, bresp_exp});
    wr_resp(10);

    // Randomized mix of reads and writes
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) a = $urandom;
      else a = ($urandom_range(0, NR - 1) * 4) | $urandom_range(0, 3);
      d = $urandom;
      s = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        wr_issue(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
        wr_resp($urandom_range(0, 3));
      end else begin
        rd(a, $urandom_range(0, 3));
      end
    end

    // 6: asynchronous reset while waiting for W
    bus.AWADDR = 32'h10; bus.AWVALID = 1;
    @(posedge ACLK); #1;
    bus.AWVALID = 0;
    chk("need_w_awready_low", bus.AWREADY, 0);
    #2 ARESET = 1;
    mdl_reset();
    #1;
    chk("async_rst_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    chk("async_rst_valids", {bus.BVALID, bus.RVALID}, 2'b00);
    chk("async_rst_regq", REG_Q, exp_regq());
    @(posedge ACLK); #1;
    ARESET = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge ACLK); #1;
      chk("no_stray_b", {bus.BVALID, WR_PULSE}, 0);
    end
    rd(32'h04, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_regfile_slave.md
Name: axil_regfile_slave

Overview:
- Parametrised AXI4-Lite slave that fronts a bank of NUM_REGS memory-mapped registers.
- Independent write and read channel FSMs; AW and W may arrive in either order or together.
- Byte strobes, read-only register mask, SLVERR on out-of-range addresses.
- Sits behind the AXI-Lite adapter top as the standard register target; register contents and per-register write pulses are exported to user logic.

Parameters:
- DATA_W, 32, AXI data width; 32 or 64.
- ADDR_W, 32, AXI address width.
- NUM_REGS, 16, number of DATA_W registers; 1..256.
- RO_MASK, 0, NUM_REGS-bit mask; bit i set makes register i read-only, with its value taken from RO_IN.
- RESET_VAL, 0, reset value of every writable register.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWVALID in 1 / AWREADY out 1 / AWADDR in ADDR_W  write address channel.
- WVALID in 1 / WREADY out 1 / WDATA in DATA_W / WSTRB in DATA_W/8  write data channel.
- BVALID out 1 / BREADY in 1 / BRESP out 2  write response channel.
- ARVALID in 1 / ARREADY out 1 / ARADDR in ADDR_W  read address channel.
- RVALID out 1 / RREADY in 1 / RDATA out DATA_W / RRESP out 2  read data channel.
- RO_IN  in  NUM_REGS*DATA_W  live values for read-only registers; slot i is bits [i*DATA_W +: DATA_W].
- REG_Q  out  NUM_REGS*DATA_W  current register contents, same slot packing.
- WR_PULSE  out  NUM_REGS  one-cycle pulse on the cycle after a committed write to register i.

Behaviour:
- Reset (async assert, released synchronously to ACLK):
  - Writable registers = RESET_VAL.
  - AWREADY = WREADY = ARREADY = 1; BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0; WR_PULSE = 0.
  - Both FSMs go to IDLE. Reset mid-transaction abandons the transaction and emits no response.
- Address decode:
  - index = ADDR[ADDR_W-1 : log2(DATA_W/8)]; low byte-offset bits are ignored.
  - index >= NUM_REGS -> response SLVERR (2'b10), otherwise OKAY (2'b00).
- Write FSM states:
  - W_IDLE: AWREADY=1, WREADY=1.
    - AW only handshaked -> latch address -> W_NEED_W.
    - W only handshaked -> latch data and strobe -> W_NEED_AW.
    - Both in the same cycle -> W_COMMIT.
  - W_NEED_W: AWREADY=0, WREADY=1; W handshake -> W_COMMIT.
  - W_NEED_AW: AWREADY=1, WREADY=0; AW handshake -> W_COMMIT.
  - W_COMMIT (one cycle, both READYs 0):
    - Byte lanes with WSTRB=1 are written into a writable, in-range register.
    - Writes to RO registers or out-of-range addresses are dropped; RO returns OKAY, out-of-range returns SLVERR.
    - WR_PULSE[index] asserts for in-range writable targets, even when WSTRB=0.
    - Sets BVALID and BRESP -> W_RESP.
  - W_RESP: BVALID held, BRESP stable until BREADY; on handshake -> W_IDLE, with READYs raised the following cycle.
  - Latency: simultaneous AW+W at edge N -> register updated at N+1 -> BVALID visible after N+1.
- Read FSM states:
  - R_IDLE: ARREADY=1; AR handshake at edge N -> RDATA/RRESP registered at N -> R_DATA (RVALID=1 from N).
  - RDATA source: register value, or RO_IN slot if RO, or 0 if out of range.
  - R_DATA: ARREADY=0; RDATA/RRESP stable until RREADY; on handshake -> R_IDLE.
- Simultaneous read and write commit to the same register on one edge: read returns the pre-write value.
- Only one outstanding transaction per channel; no ID or burst support; AxPROT is ignored.
- Channels are fully independent; a stalled BREADY must not block reads, and vice versa.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10 constants.
  - Write FSM enum {W_IDLE, W_NEED_W, W_NEED_AW, W_COMMIT, W_RESP}.
  - Read FSM enum {R_IDLE, R_DATA}.
  - Function addr_to_index.
- One sub-module, axil_reg_bank: register array with strobed byte write, RO mux, async-read port, WR_PULSE generation.
- The top holds both channel FSMs.

Test Plan:
1. AW+W same cycle, addr 0x04, data 0xDEADBEEF, WSTRB 0xF -> BVALID after 2 edges with BRESP=00; REG_Q slot 1 = 0xDEADBEEF; WR_PULSE=0x0002 for one cycle.
2. W first, AW 3 cycles later, addr 0x08, data 0x12345678, WSTRB 0x3 -> WREADY drops after the W handshake; slot 2 = 0x00005678 (from reset 0); one BVALID.
3. Read addr 0x40 with NUM_REGS=16 -> RVALID with RRESP=10 and RDATA=0. Write to addr 0x40 -> BRESP=10; REG_Q unchanged.
4. RO_MASK bit 3 set, RO_IN slot 3 = 0xCAFEF00D -> write 0x1 to 0x0C gives BRESP=00 and no change; read of 0x0C returns 0xCAFEF00D.
5. BREADY held low for 10 cycles while issuing a read of 0x04 -> read completes with 0xDEADBEEF; BVALID and BRESP stay stable throughout.
6. ARESET asserted asynchronously mid W_NEED_W -> all READYs 1, VALIDs 0, registers = RESET_VAL immediately; no stray BVALID after release.
